eq_seq_cmp: RTL
===============

Name: eq_seq_cmp

Overview:
Sequential wide-word equality controller. Compares two W-bit operands 2 bits per clock by stepping one eq2 slice comparator across the word. Gives a single-cycle done pulse, the equality flag and the index of the first mismatching slice. Used where a full W-bit comparator tree is too costly and a multi-cycle compare fits the schedule.

Parameters:
W, 16, operand width in bits; must be even and >= 4.
NS, W/2 (derived localparam), number of 2-bit slices.
IW, max(1,$clog2(NS)) (derived localparam), slice index width.

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request a compare; accepted only while ready=1
abort  in  1  synchronous cancel of a compare in progress
a  in  W  operand A, sampled on the accepting edge only
b  in  W  operand B, sampled on the accepting edge only
ready  out  1  high in IDLE
done_tick  out  1  one-cycle pulse when a result is posted
aeqb  out  1  registered result: 1 = a==b
mis_idx  out  IW  registered index of the lowest mismatching slice; 0 when aeqb=1

Behaviour:
- Reset is asynchronous and active-low. Reset value is defined by the team's port convention: clk and reset_n, with active-low asynchronous reset.
- Reset values: state=IDLE, ready=1, done_tick=0, aeqb=0, mis_idx=0, shift regs=0, slice counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. If start=1 on edge k:
  - load a_reg<=a and b_reg<=b,
  - cnt<=0, eq_acc<=1, mis_idx<=0,
  - go to RUN at k+1.
- RUN, cycle for slice i = cnt:
  - the eq2_slice compares a_reg[1:0] with b_reg[1:0],
  - a_reg and b_reg shift right by 2, and cnt increments.
  - On the first mismatch (eq_acc=1 and slice result 0): eq_acc<=0 and mis_idx<=cnt. Later mismatches do not change mis_idx.
  - When cnt==NS-1, go to DONE.
- DONE: lasts one cycle. done_tick=1, then back to IDLE.
  - aeqb and mis_idx are updated from eq_acc when DONE is entered.
  - They hold until the next accepted start, which clears aeqb to 0.
- Latency without early exit: start on edge k gives done_tick in cycle k+1+NS. Throughput is one compare per NS+2 cycles.
- start outside IDLE is ignored. It is not queued and the operands are not re-sampled.
- abort in RUN: go to IDLE next edge, no done_tick, aeqb and mis_idx unchanged from the previous result. abort in IDLE or DONE has no effect.
- If start and abort are both high in IDLE, start wins.
- Reset asserted mid-RUN: return to IDLE immediately and load the reset values. No done_tick is produced.
- cnt counts 0..NS-1 with no wrap. cnt is IW bits wide.
- Slice ordering: slice 0 is bits [1:0], and slice NS-1 is the MSB pair.

Optional Feature:
EQ_SEQ_EARLY_EXIT_EN
- Defined: on the first mismatch in RUN, go to DONE on the next edge. For a mismatch at slice i, done_tick is in cycle k+2+i. For equal operands, latency is unchanged at k+1+NS.
- Undefined: all NS slices are always scanned, so latency is fixed at k+1+NS. aeqb and mis_idx are identical in both builds.

Decomposition:
- Package eq_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  - localparam SLICE_W = 2.
- One natural sub-module, eq2_slice: a purely combinational 2-bit equality comparator using the sum-of-products form. It is instantiated once and fed from the low bits of the shift registers.

Test Plan:
(All with W=8, NS=4, start pulsed at edge k.)
- a=8'hA5, b=8'hA5: done_tick at cycle k+5, aeqb=1, mis_idx=0, ready back to 1 at k+6.
- a=8'hA5, b=8'hA4: mis_idx=0, aeqb=0. done_tick at k+2 with EQ_SEQ_EARLY_EXIT_EN, at k+5 without.
- a=8'h35, b=8'hB5: mismatch only in slice 3. aeqb=0, mis_idx=3, done_tick at k+5 in both builds.
- a=8'h00, b=8'hFF: mismatch in every slice, so mis_idx=0. A second start at k+2 with a=b=8'hFF is ignored, and the result stays aeqb=0.
- Start a=8'h12, b=8'h12, then abort at k+2: no done_tick, prior aeqb and mis_idx held, ready=1 at k+3. A new start at k+3 completes normally with aeqb=1 at k+8.
- reset_n pulled low mid-RUN, asynchronously: outputs go to their reset values before the next edge and no done_tick appears. After release, a compare of 8'h5A vs 8'h5A gives aeqb=1.

Source files
------------

// File: rtl/eq_seq_pkg.sv
// Shared types and constants for the sequential wide-word equality comparator.
package eq_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int SLICE_W = 2;

endpackage

// File: rtl/eq_seq_cmp_eq2_slice.sv
// Combinational 2-bit equality comparator in sum-of-products form.
module eq2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq
);

  // One product term per matching 2-bit value.
  assign eq = (~a[1] & ~a[0] & ~b[1] & ~b[0])
            | (~a[1] &  a[0] & ~b[1] &  b[0])
            | ( a[1] & ~a[0] &  b[1] & ~b[0])
            | ( a[1] &  a[0] &  b[1] &  b[0]);

endmodule

// File: rtl/eq_seq_cmp.sv
// Sequential W-bit equality compare, one 2-bit slice per clock.
// Define EQ_SEQ_EARLY_EXIT_EN to finish on the first mismatching slice.
module eq_seq_cmp
  import eq_seq_pkg::*;
#(
  parameter  int W  = 16,
  localparam int NS = W / SLICE_W,
  localparam int IW = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          ready,
  output logic          done_tick,
  output logic          aeqb,
  output logic [IW-1:0] mis_idx
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

  state_t        state_reg, state_next;
  logic [W-1:0]  a_reg, b_reg;
  logic [IW-1:0] cnt_reg;
  logic          eq_acc_reg;
  logic [IW-1:0] mis_acc_reg;
  logic          aeqb_reg;
  logic [IW-1:0] mis_idx_reg;

  logic slice_eq;
  logic first_mis;
  logic early_hit;
  logic go_done;

  eq2_slice u_slice (
    .a  (a_reg[SLICE_W-1:0]),
    .b  (b_reg[SLICE_W-1:0]),
    .eq (slice_eq)
  );

  assign first_mis = eq_acc_reg & ~slice_eq;

`ifdef EQ_SEQ_EARLY_EXIT_EN
  assign early_hit = first_mis;
`else
  assign early_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Abort takes priority over finishing on the last slice.
  always_comb begin
    state_next = state_reg;
    go_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (cnt_reg == LAST_IDX || early_hit) begin
          state_next = DONE;
          go_done    = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      cnt_reg     <= '0;
      eq_acc_reg  <= 1'b0;
      mis_acc_reg <= '0;
      aeqb_reg    <= 1'b0;
      mis_idx_reg <= '0;
    end else begin
      if (state_reg == IDLE && start) begin
        a_reg       <= a;
        b_reg       <= b;
        cnt_reg     <= '0;
        eq_acc_reg  <= 1'b1;
        mis_acc_reg <= '0;
        aeqb_reg    <= 1'b0;
        mis_idx_reg <= '0;
      end else if (state_reg == RUN && !abort) begin
        a_reg <= a_reg >> SLICE_W;
        b_reg <= b_reg >> SLICE_W;
        if (cnt_reg != LAST_IDX) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        if (first_mis) begin
          eq_acc_reg  <= 1'b0;
          mis_acc_reg <= cnt_reg;
        end
        // Fold in the slice being compared this cycle when posting the result.
        if (go_done) begin
          aeqb_reg    <= eq_acc_reg & slice_eq;
          mis_idx_reg <= first_mis ? cnt_reg : mis_acc_reg;
        end
      end
    end
  end

  assign ready     = (state_reg == IDLE);
  assign done_tick = (state_reg == DONE);
  assign aeqb      = aeqb_reg;
  assign mis_idx   = mis_idx_reg;

endmodule
